// File: rtl/debug_snapshot_fifo.sv
// debug_snapshot_fifo
// Captures timestamped snapshots of three debug words into a small FIFO on
// each trigger and streams them out as 4-word valid/ready bursts
// (timestamp, debug_1, debug_2, debug_3). When the FIFO is full, triggers are
// dropped and counted in a saturating counter.
// TS_START sets the timestamp value loaded at reset. It is normally 0 and is
// overridden only to exercise counter wrap.
module debug_snapshot_fifo #(
    parameter int          DEPTH    = 8,
    parameter int          DROP_W   = 8,
    parameter logic [31:0] TS_START = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              debug_1_i,
    input  logic [31:0]              debug_2_i,
    input  logic [31:0]              debug_3_i,
    input  logic                     trig_i,
    input  logic                     clr_i,
    output logic [31:0]              snap_data_o,
    output logic                     snap_vld_o,
    input  logic                     snap_rdy_i,
    output logic                     snap_last_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          idx_r, idx_s;
    logic [31:0]         ts_r;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]    level_r, level_s;
    logic                full_r;
    logic [DROP_W-1:0]   drop_r;
    logic [127:0]        mem_r [DEPTH];
    logic [31:0]         data_r, data_s;
    logic                vld_r, vld_s;
    logic                last_r, last_s;

    logic                hs_s;
    logic                pop_s;
    logic                accept_s;
    logic                drop_inc_s;
    logic                bypass_s;
    logic [PTR_W-1:0]    head_ptr_s;
    logic [127:0]        cap_snap_s;
    logic [127:0]        head_snap_s;

    // Select one 32-bit word of a snapshot: 0 = timestamp ... 3 = debug_3.
    function automatic logic [31:0] word_sel(input logic [127:0] snap, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = snap[127:96];
            2'd1:    w = snap[95:64];
            2'd2:    w = snap[63:32];
            2'd3:    w = snap[31:0];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign snap_data_o = data_r;
    assign snap_vld_o  = vld_r;
    assign snap_last_o = last_r;
    assign level_o     = level_r;
    assign full_o      = full_r;
    assign drop_cnt_o  = drop_r;

    assign cap_snap_s = {ts_r, debug_1_i, debug_2_i, debug_3_i};

    // Handshake, capture acceptance and drop decisions for this cycle.
    always_comb begin
        hs_s       = vld_r && snap_rdy_i;
        pop_s      = hs_s && last_r;
        accept_s   = trig_i && !clr_i && (!full_r || pop_s);
        drop_inc_s = trig_i && !clr_i && !accept_s;
    end

    // Next snapshot count: a capture and a final-word pop cancel each other out.
    always_comb begin
        level_s = level_r;
        if (clr_i) begin
            level_s = '0;
        end else if (accept_s && !pop_s) begin
            level_s = level_r + LVL_W'(1);
        end else if (!accept_s && pop_s) begin
            level_s = level_r - LVL_W'(1);
        end else begin
            level_s = level_r;
        end
    end

    // Output FSM next state: walks word_idx 0..3 per snapshot, chaining snapshots without a gap.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        if (clr_i) begin
            state_s = IDLE;
            idx_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    idx_s = 2'd0;
                    if (accept_s) begin
                        state_s = SEND;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SEND: begin
                    if (hs_s) begin
                        if (idx_r == 2'd3) begin
                            idx_s = 2'd0;
                            if (level_s != '0) begin
                                state_s = SEND;
                            end else begin
                                state_s = IDLE;
                            end
                        end else begin
                            state_s = SEND;
                            idx_s   = idx_r + 2'd1;
                        end
                    end else begin
                        state_s = SEND;
                        idx_s   = idx_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = 2'd0;
                end
            endcase
        end
    end

    // Next stream word. When the next head is the snapshot being written in this
    // cycle, it is taken straight from the inputs so that word 0 appears one cycle after the trigger.
    always_comb begin
        head_ptr_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        bypass_s   = accept_s && ((level_r == '0) || ((level_r == LVL_W'(1)) && pop_s));
        if (bypass_s) begin
            head_snap_s = cap_snap_s;
        end else begin
            head_snap_s = mem_r[head_ptr_s];
        end
        vld_s  = (state_s == SEND);
        last_s = vld_s && (idx_s == 2'd3);
        if (vld_s) begin
            data_s = word_sel(head_snap_s, idx_s);
        end else begin
            data_s = 32'h0000_0000;
        end
    end

    // Free-running timestamp. Only reset affects it; clear does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r <= TS_START;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    // Control state, pointers, counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= 2'd0;
            level_r  <= '0;
            full_r   <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            drop_r   <= '0;
            data_r   <= 32'h0000_0000;
            vld_r    <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            level_r <= level_s;
            full_r  <= (level_s == LVL_W'(DEPTH));
            data_r  <= data_s;
            vld_r   <= vld_s;
            last_r  <= last_s;
            if (clr_i) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                drop_r   <= '0;
            end else begin
                if (accept_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                if (drop_inc_s && (drop_r != {DROP_W{1'b1}})) begin
                    drop_r <= drop_r + DROP_W'(1);
                end
            end
        end
    end

    // Snapshot storage. It needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= cap_snap_s;
        end
    end

endmodule
